// File: rtl/csr_file.sv
// Machine/supervisor CSR file: responder for execute-unit CSR accesses, trap register
// views, 64-bit cycle/instret counters and registered M/S interrupt requests.
module csr_file #(
  parameter logic [31:0] MISA_VALUE    = 32'h40041100,
  parameter logic [31:0] MSTATUS_RESET = 32'h00001800,
  parameter logic [31:0] MTVEC_RESET   = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_csr_select,
  input  logic        i_csr_load,
  input  logic [31:0] i_csr_data,
  output logic [31:0] o_csr_reg,
  output logic [31:0] o_mstatus,
  output logic [31:0] o_sstatus,
  output logic [31:0] o_mepc,
  output logic [31:0] o_sepc,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_stvec,
  input  logic        i_msoft_irq,
  input  logic        i_mtimer_irq,
  input  logic        i_mext_irq,
  input  logic        i_retire,
  input  logic        i_exception_ecall,
  input  logic        i_exception_ebreak,
  input  logic        i_interrupt_finnished,
  output logic        o_mint_req,
  output logic        o_sint_req,
  output logic        o_illegal_csr
);

  localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;
  localparam logic [31:0] MIP_SW_MASK  = 32'h0000_0222;

  typedef enum logic [1:0] {IDLE = 2'd0, MREQ = 2'd1, SREQ = 2'd2} irq_state_e;

  irq_state_e  state_q, state_d;
  logic        mint_req_q, mint_req_d, sint_req_q, sint_req_d;
  logic [31:0] mstatus_q, mstatus_d, mideleg_q, mideleg_d, mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mip_q, mip_d;
  logic [31:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d, scause_q, scause_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] mip_sw;
  logic [5:0]  mip_p, mie_p, deleg_p, m_pend, s_pend;

  // Interrupt bits gathered in priority order: MEI MSI MTI SEI SSI STI
  assign mip_p   = {mip_q[11], mip_q[3], mip_q[7], mip_q[9], mip_q[1], mip_q[5]};
  assign mie_p   = {mie_q[11], mie_q[3], mie_q[7], mie_q[9], mie_q[1], mie_q[5]};
  assign deleg_p = {mideleg_q[11], mideleg_q[3], mideleg_q[7], mideleg_q[9], mideleg_q[1], mideleg_q[5]};
  assign m_pend  = mip_p & mie_p & ~deleg_p & {6{mstatus_q[3]}};
  assign s_pend  = mip_p & mie_p & deleg_p & {6{mstatus_q[1]}};

  function automatic logic [31:0] irq_cause(input logic [5:0] p);
    if      (p[5]) return 32'h8000_000B;
    else if (p[4]) return 32'h8000_0003;
    else if (p[3]) return 32'h8000_0007;
    else if (p[2]) return 32'h8000_0009;
    else if (p[1]) return 32'h8000_0001;
    else if (p[0]) return 32'h8000_0005;
    else           return 32'h0;
  endfunction

  assign o_mstatus  = mstatus_q;
  assign o_sstatus  = mstatus_q & SSTATUS_MASK;
  assign o_mepc     = mepc_q;
  assign o_sepc     = sepc_q;
  assign o_mtvec    = mtvec_q;
  assign o_stvec    = stvec_q;
  assign o_mint_req = mint_req_q;
  assign o_sint_req = sint_req_q;

  always_comb begin
    o_csr_reg     = '0;
    o_illegal_csr = 1'b0;
    case (i_csr_select)
      12'h300: o_csr_reg = mstatus_q;
      12'h301: begin o_csr_reg = MISA_VALUE; o_illegal_csr = i_csr_load; end
      12'h303: o_csr_reg = mideleg_q;
      12'h304: o_csr_reg = mie_q;
      12'h305: o_csr_reg = mtvec_q;
      12'h340: o_csr_reg = mscratch_q;
      12'h341: o_csr_reg = mepc_q;
      12'h342: o_csr_reg = mcause_q;
      12'h344: o_csr_reg = mip_q;
      12'h100: o_csr_reg = mstatus_q & SSTATUS_MASK;
      12'h104: o_csr_reg = mie_q & mideleg_q;
      12'h105: o_csr_reg = stvec_q;
      12'h140: o_csr_reg = sscratch_q;
      12'h141: o_csr_reg = sepc_q;
      12'h142: o_csr_reg = scause_q;
      12'h144: o_csr_reg = mip_q & mideleg_q;
      12'hB00: o_csr_reg = mcycle_q[31:0];
      12'hB80: o_csr_reg = mcycle_q[63:32];
      12'hB02: o_csr_reg = minstret_q[31:0];
      12'hB82: o_csr_reg = minstret_q[63:32];
      12'hC00: begin o_csr_reg = mcycle_q[31:0];    o_illegal_csr = i_csr_load; end
      12'hC80: begin o_csr_reg = mcycle_q[63:32];   o_illegal_csr = i_csr_load; end
      12'hC02: begin o_csr_reg = minstret_q[31:0];  o_illegal_csr = i_csr_load; end
      12'hC82: begin o_csr_reg = minstret_q[63:32]; o_illegal_csr = i_csr_load; end
      default: o_illegal_csr = 1'b1;
    endcase
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mideleg_d  = mideleg_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    stvec_d    = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
    mip_sw     = mip_q & MIP_SW_MASK;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, i_retire};
    state_d    = state_q;

    // Supervisor aliases only touch the bits their view exposes
    if (i_csr_load) begin
      case (i_csr_select)
        12'h300: mstatus_d  = i_csr_data;
        12'h303: mideleg_d  = i_csr_data;
        12'h304: mie_d      = i_csr_data;
        12'h305: mtvec_d    = {i_csr_data[31:2], 2'b00};
        12'h340: mscratch_d = i_csr_data;
        12'h341: mepc_d     = {i_csr_data[31:2], 2'b00};
        12'h342: mcause_d   = i_csr_data;
        12'h344: mip_sw     = i_csr_data & MIP_SW_MASK;
        12'h100: mstatus_d  = (mstatus_q & ~SSTATUS_MASK) | (i_csr_data & SSTATUS_MASK);
        12'h104: mie_d      = (mie_q & ~mideleg_q) | (i_csr_data & mideleg_q);
        12'h105: stvec_d    = {i_csr_data[31:2], 2'b00};
        12'h140: sscratch_d = i_csr_data;
        12'h141: sepc_d     = {i_csr_data[31:2], 2'b00};
        12'h142: scause_d   = i_csr_data;
        12'h144: mip_sw     = (mip_sw & ~mideleg_q) | (i_csr_data & mideleg_q & MIP_SW_MASK);
        12'hB00: mcycle_d[31:0]    = i_csr_data;
        12'hB80: mcycle_d[63:32]   = i_csr_data;
        12'hB02: minstret_d[31:0]  = i_csr_data;
        12'hB82: minstret_d[63:32] = i_csr_data;
        default: ;
      endcase
    end

    mip_d = mip_sw | {20'd0, i_mext_irq, 3'd0, i_mtimer_irq, 3'd0, i_msoft_irq, 3'd0};

    case (state_q)
      IDLE: begin
        if (|m_pend) begin
          state_d  = MREQ;
          mcause_d = irq_cause(m_pend);
        end else if (|s_pend) begin
          state_d  = SREQ;
          scause_d = irq_cause(s_pend);
        end
      end
      MREQ, SREQ: if (i_interrupt_finnished) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Exceptions override both the interrupt cause load and a CSR write
    if (i_exception_ecall)       mcause_d = 32'd11;
    else if (i_exception_ebreak) mcause_d = 32'd3;

    mint_req_d = (state_d == MREQ);
    sint_req_d = (state_d == SREQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      mint_req_q <= 1'b0;
      sint_req_q <= 1'b0;
      mstatus_q  <= MSTATUS_RESET;
      mideleg_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mip_q      <= '0;
      stvec_q    <= '0;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      mint_req_q <= mint_req_d;
      sint_req_q <= sint_req_d;
      mstatus_q  <= mstatus_d;
      mideleg_q  <= mideleg_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mip_q      <= mip_d;
      stvec_q    <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus a randomized run against a behavioural model.
module tb_csr_file;
  logic        i_clk, i_rst_n;
  logic [11:0] i_csr_select;
  logic        i_csr_load;
  logic [31:0] i_csr_data, o_csr_reg;
  logic [31:0] o_mstatus, o_sstatus, o_mepc, o_sepc, o_mtvec, o_stvec;
  logic        i_msoft_irq, i_mtimer_irq, i_mext_irq, i_retire;
  logic        i_exception_ecall, i_exception_ebreak, i_interrupt_finnished;
  logic        o_mint_req, o_sint_req, o_illegal_csr;

  int checks = 0;
  int errors = 0;

  csr_file dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_csr_select(i_csr_select), .i_csr_load(i_csr_load),
    .i_csr_data(i_csr_data), .o_csr_reg(o_csr_reg), .o_mstatus(o_mstatus), .o_sstatus(o_sstatus),
    .o_mepc(o_mepc), .o_sepc(o_sepc), .o_mtvec(o_mtvec), .o_stvec(o_stvec),
    .i_msoft_irq(i_msoft_irq), .i_mtimer_irq(i_mtimer_irq), .i_mext_irq(i_mext_irq),
    .i_retire(i_retire), .i_exception_ecall(i_exception_ecall),
    .i_exception_ebreak(i_exception_ebreak), .i_interrupt_finnished(i_interrupt_finnished),
    .o_mint_req(o_mint_req), .o_sint_req(o_sint_req), .o_illegal_csr(o_illegal_csr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mstatus, m_mideleg, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [31:0] m_stvec, m_sscratch, m_sepc, m_scause;
  logic [63:0] m_cycle, m_instret;
  bit          m_mreq, m_sreq;

  function automatic logic [31:0] pick_cause(input logic [31:0] p);
    int order [6] = '{11, 3, 7, 9, 1, 5};
    for (int k = 0; k < 6; k++) if (p[order[k]]) return 32'h8000_0000 | 32'(order[k]);
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h40041100;
      12'h303: return m_mideleg;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'h100: return m_mstatus & 32'h122;
      12'h104: return m_mie & m_mideleg;
      12'h105: return m_stvec;
      12'h140: return m_sscratch;
      12'h141: return m_sepc;
      12'h142: return m_scause;
      12'h144: return m_mip & m_mideleg;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_illegal(input logic [11:0] a, input logic ld);
    case (a)
      12'h301, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return ld;
      12'h300, 12'h303, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
      12'h100, 12'h104, 12'h105, 12'h140, 12'h141, 12'h142, 12'h144,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h1800; m_mtvec = 32'h0;
    m_mideleg = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mip = 0;
    m_stvec = 0; m_sscratch = 0; m_sepc = 0; m_scause = 0;
    m_cycle = 0; m_instret = 0; m_mreq = 0; m_sreq = 0;
  endtask

  task automatic model_step();
    logic [31:0] act, pm, ps, d;
    logic [63:0] cyc, ins;
    act = m_mip & m_mie;
    pm  = m_mstatus[3] ? (act & ~m_mideleg) : 32'h0;
    ps  = m_mstatus[1] ? (act & m_mideleg) : 32'h0;
    cyc = m_cycle + 64'd1;
    ins = m_instret + (i_retire ? 64'd1 : 64'd0);
    d   = i_csr_data;
    if (i_csr_load) begin
      case (i_csr_select)
        12'h300: m_mstatus = d;
        12'h100: m_mstatus = (m_mstatus & ~32'h122) | (d & 32'h122);
        12'h303: m_mideleg = d;
        12'h304: m_mie = d;
        12'h104: m_mie = (m_mie & ~m_mideleg) | (d & m_mideleg);
        12'h305: m_mtvec = d & ~32'h3;
        12'h105: m_stvec = d & ~32'h3;
        12'h340: m_mscratch = d;
        12'h140: m_sscratch = d;
        12'h341: m_mepc = d & ~32'h3;
        12'h141: m_sepc = d & ~32'h3;
        12'h342: m_mcause = d;
        12'h142: m_scause = d;
        12'h344: m_mip = (m_mip & ~32'h222) | (d & 32'h222);
        12'h144: m_mip = (m_mip & ~(32'h222 & m_mideleg)) | (d & 32'h222 & m_mideleg);
        12'hB00: cyc[31:0] = d;
        12'hB80: cyc[63:32] = d;
        12'hB02: ins[31:0] = d;
        12'hB82: ins[63:32] = d;
        default: ;
      endcase
    end
    m_mip = (m_mip & 32'h222) | (i_msoft_irq ? 32'h8 : 32'h0) |
            (i_mtimer_irq ? 32'h80 : 32'h0) | (i_mext_irq ? 32'h800 : 32'h0);
    if (m_mreq || m_sreq) begin
      if (i_interrupt_finnished) begin m_mreq = 0; m_sreq = 0; end
    end else if (pm != 0) begin
      m_mreq = 1; m_mcause = pick_cause(pm);
    end else if (ps != 0) begin
      m_sreq = 1; m_scause = pick_cause(ps);
    end
    if (i_exception_ecall)       m_mcause = 32'd11;
    else if (i_exception_ebreak) m_mcause = 32'd3;
    m_cycle = cyc;
    m_instret = ins;
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) model_reset();
    else          model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    i_csr_select = a; i_csr_load = 1'b1; i_csr_data = d;
    tick();
    i_csr_load = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    i_csr_select = a; i_csr_load = 1'b0; #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst_n = 1'b1; i_csr_select = 12'h300; i_csr_load = 0; i_csr_data = 0;
    i_msoft_irq = 0; i_mtimer_irq = 0; i_mext_irq = 0; i_retire = 0;
    i_exception_ecall = 0; i_exception_ebreak = 0; i_interrupt_finnished = 0;
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_mint_req !== 1'b0) begin errors++; $display("FAIL rst_mint got %b exp 0", o_mint_req); end
    checks++; if (o_mstatus !== 32'h1800) begin errors++; $display("FAIL rst_mstatus got %h exp 00001800", o_mstatus); end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    rd(12'h300);
    checks++; if (o_csr_reg !== 32'h1800) begin errors++; $display("FAIL rd_mstatus got %h exp 00001800", o_csr_reg); end
    rd(12'h301);
    checks++; if (o_csr_reg !== 32'h40041100) begin errors++; $display("FAIL rd_misa got %h exp 40041100", o_csr_reg); end
    rd(12'h305);
    checks++; if (o_csr_reg !== 32'h0) begin errors++; $display("FAIL rd_mtvec got %h exp 0", o_csr_reg); end
    rd(12'hB00);
    checks++; if (o_csr_reg !== 32'h0) begin errors++; $display("FAIL rd_mcycle got %h exp 0", o_csr_reg); end
    checks++; if (o_mint_req !== 1'b0 || o_sint_req !== 1'b0)
      begin errors++; $display("FAIL rst_reqs got %b%b exp 00", o_mint_req, o_sint_req); end
    tick();
  endtask

  task automatic test_tvec_misa();
    i_csr_select = 12'h305; i_csr_load = 1'b1; i_csr_data = 32'h103; #1;
    checks++; if (o_mtvec !== 32'h0) begin errors++; $display("FAIL mtvec_early got %h exp 0", o_mtvec); end
    tick(); i_csr_load = 1'b0;
    rd(12'h305);
    checks++; if (o_csr_reg !== 32'h100) begin errors++; $display("FAIL rd_mtvec got %h exp 00000100", o_csr_reg); end
    checks++; if (o_mtvec !== 32'h100) begin errors++; $display("FAIL o_mtvec got %h exp 00000100", o_mtvec); end
    i_csr_select = 12'h301; i_csr_load = 1'b1; i_csr_data = 32'hDEADBEEF; #1;
    checks++; if (o_illegal_csr !== 1'b1) begin errors++; $display("FAIL misa_wr_illegal got %b exp 1", o_illegal_csr); end
    tick(); i_csr_load = 1'b0;
    rd(12'h301);
    checks++; if (o_csr_reg !== 32'h40041100) begin errors++; $display("FAIL misa_kept got %h exp 40041100", o_csr_reg); end
    checks++; if (o_illegal_csr !== 1'b0) begin errors++; $display("FAIL misa_rd_illegal got %b exp 0", o_illegal_csr); end
    rd(12'h7C0);
    checks++; if (o_csr_reg !== 32'h0 || o_illegal_csr !== 1'b1)
      begin errors++; $display("FAIL unimpl got %h/%b exp 0/1", o_csr_reg, o_illegal_csr); end
    wr(12'h105, 32'hFFFF_FFFF);
    checks++; if (o_stvec !== 32'hFFFF_FFFC) begin errors++; $display("FAIL o_stvec got %h exp fffffffc", o_stvec); end
  endtask

  task automatic test_mint();
    bit got;
    wr(12'h304, 32'h880);
    wr(12'h300, 32'h1808);
    i_mtimer_irq = 1'b1; i_mext_irq = 1'b1;
    got = 0;
    for (int k = 0; k < 2 && !got; k++) begin tick(); got = o_mint_req; end
    checks++; if (o_mint_req !== 1'b1) begin errors++; $display("FAIL mint_rise got %b exp 1", o_mint_req); end
    rd(12'h342);
    checks++; if (o_csr_reg !== 32'h8000000B) begin errors++; $display("FAIL mcause_mei got %h exp 8000000b", o_csr_reg); end
    checks++; if (o_sint_req !== 1'b0) begin errors++; $display("FAIL sint_quiet got %b exp 0", o_sint_req); end
    i_mtimer_irq = 1'b0; i_mext_irq = 1'b0;
    tick(); tick();
    checks++; if (o_mint_req !== 1'b1) begin errors++; $display("FAIL mint_hold got %b exp 1", o_mint_req); end
    i_interrupt_finnished = 1'b1; tick(); i_interrupt_finnished = 1'b0;
    checks++; if (o_mint_req !== 1'b0) begin errors++; $display("FAIL mint_drop got %b exp 0", o_mint_req); end
    wr(12'h300, 32'h1800);
  endtask

  task automatic test_sint();
    wr(12'h303, 32'h20);
    wr(12'h304, 32'h20);
    wr(12'h100, 32'h2);
    checks++; if (o_mstatus !== 32'h1802 || o_sstatus !== 32'h2)
      begin errors++; $display("FAIL sstatus_wr got %h/%h exp 00001802/00000002", o_mstatus, o_sstatus); end
    wr(12'h144, 32'h20);
    tick();
    checks++; if (o_sint_req !== 1'b1) begin errors++; $display("FAIL sint_rise got %b exp 1", o_sint_req); end
    checks++; if (o_mint_req !== 1'b0) begin errors++; $display("FAIL mint_quiet got %b exp 0", o_mint_req); end
    rd(12'h142);
    checks++; if (o_csr_reg !== 32'h80000005) begin errors++; $display("FAIL scause_sti got %h exp 80000005", o_csr_reg); end
    rd(12'h144);
    checks++; if (o_csr_reg !== 32'h20) begin errors++; $display("FAIL sip got %h exp 00000020", o_csr_reg); end
    i_interrupt_finnished = 1'b1;
    wr(12'h144, 32'h0);
    i_interrupt_finnished = 1'b0;
    checks++; if (o_sint_req !== 1'b0) begin errors++; $display("FAIL sint_drop got %b exp 0", o_sint_req); end
    tick();
    checks++; if (o_sint_req !== 1'b0) begin errors++; $display("FAIL sint_stay got %b exp 0", o_sint_req); end
  endtask

  task automatic test_exceptions();
    i_exception_ecall = 1'b1; tick(); i_exception_ecall = 1'b0;
    rd(12'h342);
    checks++; if (o_csr_reg !== 32'd11) begin errors++; $display("FAIL ecall_cause got %h exp 0000000b", o_csr_reg); end
    i_exception_ebreak = 1'b1; tick(); i_exception_ebreak = 1'b0;
    rd(12'h342);
    checks++; if (o_csr_reg !== 32'd3) begin errors++; $display("FAIL ebreak_cause got %h exp 00000003", o_csr_reg); end
    i_exception_ecall = 1'b1; wr(12'h342, 32'h55); i_exception_ecall = 1'b0;
    rd(12'h342);
    checks++; if (o_csr_reg !== 32'd11) begin errors++; $display("FAIL exc_vs_wr got %h exp 0000000b", o_csr_reg); end
    wr(12'h341, 32'hFFFF_FFFF);
    checks++; if (o_mepc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mepc_align got %h exp fffffffc", o_mepc); end
    wr(12'h141, 32'h1234_5677);
    checks++; if (o_sepc !== 32'h1234_5674) begin errors++; $display("FAIL sepc_align got %h exp 12345674", o_sepc); end
  endtask

  task automatic test_counters();
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00);
    checks++; if (o_csr_reg !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_lo_wr got %h exp ffffffff", o_csr_reg); end
    tick();
    rd(12'hB00);
    checks++; if (o_csr_reg !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo got %h exp 0", o_csr_reg); end
    rd(12'hB80);
    checks++; if (o_csr_reg !== 32'h1) begin errors++; $display("FAIL mcycle_carry_hi got %h exp 1", o_csr_reg); end
    rd(12'hC80);
    checks++; if (o_csr_reg !== 32'h1) begin errors++; $display("FAIL cycleh_alias got %h exp 1", o_csr_reg); end
    wr(12'hB82, 32'h0);
    wr(12'hB02, 32'h0);
    repeat (3) begin i_retire = 1'b1; tick(); i_retire = 1'b0; tick(); end
    rd(12'hB02);
    checks++; if (o_csr_reg !== 32'd3) begin errors++; $display("FAIL minstret got %h exp 3", o_csr_reg); end
    rd(12'hC02);
    checks++; if (o_csr_reg !== 32'd3) begin errors++; $display("FAIL instret_alias got %h exp 3", o_csr_reg); end
    i_csr_select = 12'hC00; i_csr_load = 1'b1; i_csr_data = 32'h0; #1;
    checks++; if (o_illegal_csr !== 1'b1) begin errors++; $display("FAIL ro_alias_wr got %b exp 1", o_illegal_csr); end
    tick(); i_csr_load = 1'b0;
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    tick(); tick();
    rd(12'hB00);
    checks++; if (o_csr_reg !== 32'h0 || o_csr_reg !== m_cycle[31:0])
      begin errors++; $display("FAIL wrap_lo got %h exp 0 (model %h)", o_csr_reg, m_cycle[31:0]); end
    rd(12'hB80);
    checks++; if (o_csr_reg !== 32'h0 || o_csr_reg !== m_cycle[63:32])
      begin errors++; $display("FAIL wrap_hi got %h exp 0 (model %h)", o_csr_reg, m_cycle[63:32]); end
  endtask

  logic [11:0] addrs [24] = '{12'h300, 12'h301, 12'h303, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h344, 12'h100, 12'h104, 12'h105, 12'h140, 12'h141, 12'h142, 12'h144,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};

  task automatic test_random();
    int r;
    for (int n = 0; n < 500; n++) begin
      i_csr_select = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 23)];
      i_csr_load   = ($urandom_range(0, 2) == 0);
      i_csr_data   = $urandom;
      if ($urandom_range(0, 5) == 0) {i_mext_irq, i_mtimer_irq, i_msoft_irq} = 3'($urandom);
      i_retire = 1'($urandom);
      r = $urandom_range(0, 15);
      i_exception_ecall  = (r == 0);
      i_exception_ebreak = (r == 1);
      i_interrupt_finnished = ($urandom_range(0, 4) == 0);
      #2;
      checks++; if (o_csr_reg !== model_read(i_csr_select))
        begin errors++; $display("FAIL rnd_read n=%0d a=%h got %h exp %h", n, i_csr_select, o_csr_reg, model_read(i_csr_select)); end
      checks++; if (o_illegal_csr !== model_illegal(i_csr_select, i_csr_load))
        begin errors++; $display("FAIL rnd_illegal n=%0d a=%h got %b", n, i_csr_select, o_illegal_csr); end
      checks++; if (o_mint_req !== m_mreq || o_sint_req !== m_sreq)
        begin errors++; $display("FAIL rnd_req n=%0d got %b%b exp %b%b", n, o_mint_req, o_sint_req, m_mreq, m_sreq); end
      checks++; if (o_mstatus !== m_mstatus || o_sstatus !== (m_mstatus & 32'h122))
        begin errors++; $display("FAIL rnd_status n=%0d got %h/%h exp %h", n, o_mstatus, o_sstatus, m_mstatus); end
      checks++; if (o_mepc !== m_mepc || o_sepc !== m_sepc || o_mtvec !== m_mtvec || o_stvec !== m_stvec)
        begin errors++; $display("FAIL rnd_views n=%0d got %h %h %h %h", n, o_mepc, o_sepc, o_mtvec, o_stvec); end
      tick();
    end
    i_csr_load = 0; i_retire = 0; i_exception_ecall = 0; i_exception_ebreak = 0;
    i_msoft_irq = 0; i_mtimer_irq = 0; i_mext_irq = 0;
    i_interrupt_finnished = 1'b1;
    wr(12'h300, 32'h1800);
    tick();
    i_interrupt_finnished = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr(12'h303, 32'h0);
    wr(12'h304, 32'h8);
    wr(12'h300, 32'h1808);
    i_msoft_irq = 1'b1;
    tick(); tick();
    checks++; if (o_mint_req !== 1'b1) begin errors++; $display("FAIL pre_rst_mint got %b exp 1", o_mint_req); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_mint_req !== 1'b0) begin errors++; $display("FAIL rst_mid_mint got %b exp 0", o_mint_req); end
    checks++; if (o_mstatus !== 32'h1800) begin errors++; $display("FAIL rst_mid_mstatus got %h exp 00001800", o_mstatus); end
    rd(12'hB00);
    checks++; if (o_csr_reg !== 32'h0) begin errors++; $display("FAIL rst_mid_cycle got %h exp 0", o_csr_reg); end
    rd(12'hB02);
    checks++; if (o_csr_reg !== 32'h0) begin errors++; $display("FAIL rst_mid_instret got %h exp 0", o_csr_reg); end
    rd(12'h342);
    checks++; if (o_csr_reg !== 32'h0) begin errors++; $display("FAIL rst_mid_mcause got %h exp 0", o_csr_reg); end
    @(posedge i_clk); #1;
    i_msoft_irq = 1'b0;
    i_rst_n = 1'b1;
    tick(); tick();
    checks++; if (o_mint_req !== 1'b0) begin errors++; $display("FAIL post_rst_mint got %b exp 0", o_mint_req); end
  endtask

  initial begin
    test_reset();
    test_tvec_misa();
    test_mint();
    test_sint();
    test_exceptions();
    test_counters();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine/supervisor CSR register file. It is the responder to the execute unit's CSR access interface (select/load/data) and the source of the mstatus/sstatus/epc/tvec views the execute unit consumes.
- Holds the interrupt-enable, pending and delegation state, plus the cycle and instret counters.
- Produces registered machine and supervisor interrupt requests toward the control unit's MINT/SINT states.
- Latches the cause on interrupt entry and on ecall/ebreak.

Parameters:
MISA_VALUE, 32'h40041100, read-only misa contents (RV32 I M S).
MSTATUS_RESET, 32'h00001800, mstatus reset value (MPP=11).
MTVEC_RESET, 32'h00000000, mtvec reset value.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_csr_select  in  12  CSR address for read and write
i_csr_load  in  1  write strobe; i_csr_data written at posedge
i_csr_data  in  32  write data
o_csr_reg  out  32  combinational read of i_csr_select
o_mstatus, o_sstatus, o_mepc, o_sepc, o_mtvec, o_stvec  out  32 each  continuous register views
i_msoft_irq, i_mtimer_irq, i_mext_irq  in  1 each  level interrupt sources
i_retire  in  1  one-cycle pulse per retired instruction
i_exception_ecall, i_exception_ebreak  in  1 each  exception pulses
i_interrupt_finnished  in  1  control unit completed trap entry
o_mint_req, o_sint_req  out  1 each  registered interrupt requests
o_illegal_csr  out  1  combinational; selected address is unimplemented, or a write targets a read-only CSR

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET. All other registers, counters, o_mint_req and o_sint_req are 0.
- Implemented CSR addresses:
  - 300 mstatus, 301 misa (read-only), 303 mideleg, 304 mie, 305 mtvec.
  - 340 mscratch, 341 mepc, 342 mcause, 344 mip.
  - 100 sstatus, 104 sie, 105 stvec, 140 sscratch, 141 sepc, 142 scause, 144 sip.
  - B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi, C00/C80/C02/C82 user read-only aliases of the counters.
- Unimplemented address: reads return 0 and writes are ignored.
- sstatus is a masked view of mstatus, mask 32'h00000122 (SPP bit 8, SPIE bit 5, SIE bit 1). A write to 100 changes only the masked bits. sie and sip are views of mie and mip masked by mideleg.
- epc writes force bits[1:0]=0. tvec writes force bits[1:0]=0 (direct mode only).
- mip:
  - Bits 3, 7, 11 are registered each cycle from i_msoft_irq, i_mtimer_irq, i_mext_irq and are read-only.
  - Bits 1, 5, 9 are software-writable through 344 or 144.
- Read path: o_csr_reg is combinational and reflects the register value before any same-cycle write.
- Counters:
  - mcycle is 64 bit and increments every cycle. minstret is 64 bit and increments on i_retire.
  - The carry from lo propagates into hi in the same cycle.
  - A CSR write to either half wins over the increment in that cycle; the other half still takes its normal update.
  - Wrap from 2^64-1 to 0.
- Exceptions: i_exception_ecall loads mcause=11; i_exception_ebreak loads mcause=3. If a CSR write to 342 occurs in the same cycle, the exception wins.
- Interrupt pending terms:
  - m_pend = mip & mie & ~mideleg, gated by mstatus.MIE (bit 3).
  - s_pend = mip & mie & mideleg, gated by mstatus.SIE (bit 1).
- Interrupt request FSM, states IDLE, MREQ, SREQ:
  - IDLE to MREQ when m_pend is non-zero. o_mint_req rises on the next edge. mcause loads {1'b1, code} on that edge, with code priority MEI 11 > MSI 3 > MTI 7 > SEI 9 > SSI 1 > STI 5.
  - IDLE to SREQ when m_pend is zero and s_pend is non-zero. scause loads the same way.
  - MREQ/SREQ hold the request until i_interrupt_finnished, then return to IDLE and deassert the request on that edge.
  - A pending source that drops while in MREQ/SREQ does not withdraw the request.
  - MREQ and SREQ are never active together. The cause is not reloaded while in MREQ/SREQ.
- Simultaneous events:
  - An exception arriving in MREQ latches mcause; the interrupt cause is overwritten.
  - A CSR write and an interrupt-cause load to the same register in the same cycle: the interrupt load wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); requests drop the same cycle.

Test Plan:
1. Reset, then read 300, 301, 305 -> 32'h00001800, 32'h40041100, 0; o_mint_req=0.
2. Write mtvec=32'h00000103 -> read 305 = 32'h00000100 and o_mtvec updates the next cycle; write 301 -> o_illegal_csr=1 and misa unchanged.
3. mie=32'h880, mstatus.MIE=1, raise i_mtimer_irq and i_mext_irq together -> o_mint_req=1 within 2 cycles, mcause=32'h8000000B; pulse i_interrupt_finnished -> o_mint_req=0 on the next edge.
4. mideleg=32'h020, mie=32'h020, mstatus.SIE=1, write sip bit 5 -> o_sint_req=1, scause=32'h80000005, o_mint_req stays 0.
5. Write mcycle lo=32'hFFFFFFFF, hi=0 -> after 1 cycle mcycleh=1, lo=0; i_retire pulsed 3 times -> minstret=3.
6. Assert i_rst_n=0 while o_mint_req=1 and mid-count -> outputs and counters 0 immediately, mstatus=32'h00001800.
